// File: rtl/viterbi_decoder_param.sv
// Framed rate-1/2 soft-decision Viterbi decoder, 2^(K-1) states, register-exchange survivors.
// Define VITERBI_TERMINATED_EN to flush from state 0 (zero-tail frames) instead of the best state.
module viterbi_decoder_param #(
  parameter int unsigned  K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101,
  parameter int unsigned  QB = 3,
  parameter int unsigned  TB = 16,
  parameter int unsigned  MW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [QB-1:0] y1,
  input  logic [QB-1:0] y2,
  output logic          decoded_bit,
  output logic          data_valid,
  output logic          out_last
);

  localparam int unsigned NS = 2 ** (K - 1);
  localparam int unsigned SW = K - 1;
  localparam int unsigned CW = $clog2(TB + 1);
  localparam logic [MW-1:0] PmInit = MW'(1) << (MW - 2);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   pm_q [NS];
  logic [MW-1:0]   pm_d [NS];
  logic [TB-1:0]   surv_q [NS];
  logic [TB-1:0]   surv_d [NS];
  logic [CW-1:0]   cnt_q, cnt_d, cnt_acc;
  logic [TB-1:0]   flush_q, flush_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            dec_q, dec_d, dv_q, dv_d, last_q, last_d;

  logic            accept, start, all_msb;
  logic [MW-1:0]   pm_base [NS];
  logic [TB-1:0]   surv_base [NS];
  logic [MW-1:0]   cand0 [NS];
  logic [MW-1:0]   cand1 [NS];
  logic [MW-1:0]   pm_acs [NS];
  logic [MW-1:0]   pm_norm [NS];
  logic [TB-1:0]   prev_surv [NS];
  logic [TB-1:0]   surv_acs [NS];
  logic [SW-1:0]   best, flush_sel;
  logic [MW-1:0]   best_pm;

  // Cost of the branch into state n from predecessor {n[K-3:0], x}; register is {n, x}.
  function automatic logic [MW-1:0] branch_cost(input int unsigned n, input int unsigned x,
                                                input logic [QB-1:0] a, input logic [QB-1:0] b);
    logic [K-1:0] r;
    logic [QB:0]  ta, tb;
    r  = K'((n << 1) | x);
    ta = {1'b0, (^(r & G0)) ? ~a : a};
    tb = {1'b0, (^(r & G1)) ? ~b : b};
    return MW'(ta + tb);
  endfunction

  // Returns v[pos-1] without a width-mismatched variable bit select.
  function automatic logic pick_bit(input logic [TB-1:0] v, input logic [CW-1:0] pos);
    logic bit_out;
    bit_out = 1'b0;
    for (int unsigned i = 0; i < TB; i++) begin
      if (CW'(i + 1) == pos) bit_out = v[i];
    end
    return bit_out;
  endfunction

  assign in_ready = (state_q != StFlush);
  assign accept   = in_valid && in_ready;
  assign start    = accept && (in_first || (state_q == StIdle));
  assign cnt_acc  = start ? CW'(1) : ((cnt_q == CW'(TB)) ? cnt_q : cnt_q + CW'(1));

  always_comb begin
    for (int unsigned n = 0; n < NS; n++) begin
      pm_base[n]   = start ? ((n == 0) ? '0 : PmInit) : pm_q[n];
      surv_base[n] = start ? '0 : surv_q[n];
    end
  end

  always_comb begin
    all_msb = 1'b1;
    for (int unsigned n = 0; n < NS; n++) begin
      cand0[n] = pm_base[(2 * n) % NS] + branch_cost(n, 0, y1, y2);
      cand1[n] = pm_base[(2 * n) % NS + 1] + branch_cost(n, 1, y1, y2);
      if (cand1[n] < cand0[n]) begin
        pm_acs[n]    = cand1[n];
        prev_surv[n] = surv_base[(2 * n) % NS + 1];
      end else begin
        pm_acs[n]    = cand0[n];
        prev_surv[n] = surv_base[(2 * n) % NS];
      end
      surv_acs[n] = {prev_surv[n][TB-2:0], 1'(n >> (K - 2))};
      all_msb     = all_msb & pm_acs[n][MW-1];
    end
    for (int unsigned n = 0; n < NS; n++) begin
      pm_norm[n] = all_msb ? {1'b0, pm_acs[n][MW-2:0]} : pm_acs[n];
    end
    best    = '0;
    best_pm = pm_norm[0];
    for (int unsigned n = 1; n < NS; n++) begin
      if (pm_norm[n] < best_pm) begin
        best    = SW'(n);
        best_pm = pm_norm[n];
      end
    end
  end

`ifdef VITERBI_TERMINATED_EN
  assign flush_sel = '0;
`else
  assign flush_sel = best;
`endif

  always_comb begin
    state_d = state_q;
    pm_d    = pm_q;
    surv_d  = surv_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    rem_d   = rem_q;
    dec_d   = 1'b0;
    dv_d    = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          pm_d   = pm_norm;
          surv_d = surv_acs;
          cnt_d  = cnt_acc;
          if (in_last) begin
            // First flush bit goes out now; rem counts the bits still held after it.
            flush_d = surv_acs[flush_sel];
            dec_d   = pick_bit(surv_acs[flush_sel], cnt_acc);
            dv_d    = 1'b1;
            last_d  = (cnt_acc == CW'(1));
            rem_d   = cnt_acc - CW'(1);
            state_d = StFlush;
          end else begin
            state_d = StRun;
            if (cnt_acc == CW'(TB)) begin
              dv_d  = 1'b1;
              dec_d = surv_acs[best][TB-1];
            end
          end
        end
      end
      StFlush: begin
        if (rem_q == '0) begin
          state_d = StIdle;
        end else begin
          dv_d   = 1'b1;
          dec_d  = pick_bit(flush_q, rem_q);
          last_d = (rem_q == CW'(1));
          rem_d  = rem_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int unsigned n = 0; n < NS; n++) begin
        pm_q[n]   <= '0;
        surv_q[n] <= '0;
      end
      cnt_q   <= '0;
      flush_q <= '0;
      rem_q   <= '0;
      dec_q   <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pm_q    <= pm_d;
      surv_q  <= surv_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      rem_q   <= rem_d;
      dec_q   <= dec_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
    end
  end

  assign decoded_bit = dec_q;
  assign data_valid  = dv_q;
  assign out_last    = last_q;

endmodule

// File: doc/viterbi_decoder_param.md
Name: viterbi_decoder_param

Overview:
Parametrised, framed, rate-1/2 soft-decision Viterbi decoder. It generalises the fixed 4-state decoder to 2^(K-1) states, with configurable generator polynomials, soft-bit width and survivor depth. Each symbol goes through a single-cycle add-compare-select step, and survivors are kept in register-exchange form. Frame boundaries are explicit, and the block flushes at frame end, so every accepted symbol produces exactly one decoded bit.

Parameters:
K, 3, constraint length (3..7); number of states NS = 2^(K-1)
G0, 3'b111, generator for y1, K bits; bit K-1 taps the newest input
G1, 3'b101, generator for y2, K bits
QB, 3, soft-bit width
TB, 16, survivor (decision) depth in symbols, >= 2
MW, 8, path-metric width; must be >= QB+4

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  symbol present
in_ready  out  1  symbol can be accepted
in_first  in  1  first symbol of frame, qualified by accept
in_last  in  1  last symbol of frame, qualified by accept
y1  in  QB  soft bit for G0: 0 = strong 0, 2^QB-1 = strong 1
y2  in  QB  soft bit for G1
decoded_bit  out  1  decoded bit, chronological order
data_valid  out  1  decoded_bit valid this cycle (no backpressure)
out_last  out  1  last decoded bit of frame

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is synchronous and active-high.
  - Effect: FSM goes to IDLE; in_ready=1; data_valid=0; out_last=0; decoded_bit=0.
  - Metrics and survivors are cleared; symbol counter is 0.
  - rst mid-frame or mid-flush discards everything, with no partial output.
- Accept condition: in_valid && in_ready. in_ready = (state != FLUSH).
- Encoder convention:
  - state s is K-1 bits; register r = {u, s}; c_i = ^(r & G_i); next state = r[K-1:1].
  - Predecessors of state n: {n[K-3:0], x} for x in {0,1}; the decision bit is u = n[K-2].
- Branch metric: bm(y,c) = c ? (2^QB-1-y) : y. Total = bm(y1,c0) + bm(y2,c1), QB+1 bits, unsigned.
- ACS: pm'[n] = min over x of pm[pred_x] + bm.
  - A tie selects x=0.
  - Survivor: surv'[n] = {surv[pred_sel][TB-2:0], u}, TB bits, newest bit at LSB.
- Normalisation: if every pm' has MSB set, clear the MSB of all states in the same cycle. Metrics never wrap otherwise.
- Frame start: an accept with in_first first loads pm[0]=0 and pm[others]=2^(MW-2), then performs that symbol's ACS. The counter is set to 1.
  - in_first while in RUN abandons the old frame; its unemitted bits are dropped.
- Accept without in_first in IDLE: treated as if in_first were set.
- FSM IDLE -> RUN on the first accept.
- RUN, with count c after the accept:
  - If c >= TB, the next cycle has data_valid=1 and decoded_bit = bit TB-1 of surv' of the selected state.
  - Selected state = min pm', lowest index on ties.
- RUN + accept with in_last:
  - Latch the selected survivor into a flush register.
  - R = min(c, TB) bits remain, oldest first.
  - Go to FLUSH. Emit one bit per cycle, starting the cycle after the accept; when c >= TB, that first emission replaces the normal RUN output for that accept.
  - out_last=1 with the final bit, then go to IDLE. in_ready returns to 1 the cycle after out_last.
- Latency: bit j of a frame (j = 0-based) appears 1 cycle after accept of symbol j+TB-1, or during the flush.
- Single-symbol frame (in_first && in_last): one bit, with data_valid and out_last in the next cycle.
- Gaps: in_valid gaps do not advance the trellis and produce no output.

Optional Feature:
VITERBI_TERMINATED_EN
- Defined: frames are assumed zero-tail terminated. At in_last the flush register is loaded from surv' of state 0, regardless of metrics. Normal RUN output still uses the min-metric state.
- Undefined: the flush uses the min-metric state, lowest index on ties.

Test Plan:
- Clean frame: K=3, G 111/101, QB=3, TB=4. Message 1,0,1,1,0,0 gives code pairs 11,10,00,01,01,11 (soft 0/7), sent back-to-back with first/last. Required output: 1,0,1,1,0,0, six data_valid pulses, out_last on the 6th, and in_ready low during the flush.
- Soft error: same frame with symbol 3's y1 = 4 instead of 0 (weak flip). Required output: unchanged 1,0,1,1,0,0.
- Short frame: a 2-symbol frame (pairs 11,10) with TB=4. Required output: 1,0 in the two cycles after the last accept, with out_last on the second.
- Long frame with normalisation: 200 random bits plus a 2-bit zero tail, every symbol erased to y=3. Required: no metric wrap (matches a wide-metric reference model), all 202 bits emitted in order.
- Reset and resync: rst asserted mid-flush. Required: data_valid=0 the cycle after; the next frame decodes correctly. An in_first mid-frame must drop the old frame's pending bits.
- Macro: a frame whose final metrics favour state 2 over state 0. Required: the flush follows state 0 with VITERBI_TERMINATED_EN and state 2 without it, each matching the reference model.
